min_pair_scan_ctrl: RTL and testbench



---
 rtl/min_pair_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_min_pair_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_pair_scan_ctrl.sv
// Scans up to 2^GW four-lane magnitude words and reports the two smallest nonzero
// entries with their addresses. Define MINPAIR_EXCL_EN to add per-scan entry exclusion.
module min_pair_scan_ctrl #(
    parameter int DW = 11,
    parameter int GW = 5,
    parameter int AW = GW + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [GW:0]     num_groups,
    output logic            rd_en,
    output logic [GW-1:0]   rd_addr,
    input  logic [4*DW-1:0] rd_data,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   min1,
    output logic [DW-1:0]   min2,
    output logic [AW-1:0]   min1_addr,
    output logic [AW-1:0]   min2_addr,
    output logic [1:0]      found_cnt
`ifdef MINPAIR_EXCL_EN
    ,
    input  logic            excl_en,
    input  logic [AW-1:0]   excl_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [GW:0] MAX_GROUPS = {1'b1, {GW{1'b0}}};

    // Candidate a beats b: zero never wins, smaller value wins, lower address breaks ties.
    function automatic logic beats(input logic [DW-1:0] va, input logic [AW-1:0] aa,
                                   input logic [DW-1:0] vb, input logic [AW-1:0] ab);
        beats = (va != {DW{1'b0}}) &&
                ((vb == {DW{1'b0}}) || (va < vb) || ((va == vb) && (aa < ab)));
    endfunction

    function automatic logic [1:0] count_found(input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        if (v2 != {DW{1'b0}}) begin
            count_found = 2'd2;
        end else if (v1 != {DW{1'b0}}) begin
            count_found = 2'd1;
        end else begin
            count_found = 2'd0;
        end
    endfunction

    state_t          state_r, next_state_s;
    logic [GW:0]     ng_r;
    logic [GW:0]     ng_clamp_s;
    logic            start_acc_s;
    logic            last_s;
    logic            data_vld_r;
    logic [GW-1:0]   data_grp_r;
    logic [DW-1:0]   run1_v_r, run2_v_r;
    logic [AW-1:0]   run1_a_r, run2_a_r;
    logic [DW-1:0]   lane_v_s [4];
    logic [AW-1:0]   lane_a_s [4];
    logic [DW-1:0]   m1_v_s, m2_v_s;
    logic [AW-1:0]   m1_a_s, m2_a_s;
`ifdef MINPAIR_EXCL_EN
    logic            excl_en_r;
    logic [AW-1:0]   excl_addr_r;
`endif

    assign start_acc_s = (state_r == IDLE) && start;
    assign ng_clamp_s  = (num_groups > MAX_GROUPS) ? MAX_GROUPS : num_groups;
    assign last_s      = ({1'b0, rd_addr} == (ng_r - {{GW{1'b0}}, 1'b1}));

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (ng_clamp_s == {(GW+1){1'b0}}) ? FLUSH : READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                if (last_s) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = READ;
                end
            end
            FLUSH: next_state_s = OUT;
            OUT: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered control outputs, group counter and per-scan configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= {GW{1'b0}};
            busy      <= 1'b0;
            out_valid <= 1'b0;
            ng_r      <= {(GW+1){1'b0}};
        end else begin
            rd_en     <= (next_state_s == READ);
            busy      <= (next_state_s == READ) || (next_state_s == FLUSH);
            out_valid <= (next_state_s == OUT);
            if (start_acc_s) begin
                ng_r    <= ng_clamp_s;
                rd_addr <= {GW{1'b0}};
            end else if ((state_r == READ) && !last_s) begin
                rd_addr <= rd_addr + {{(GW-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef MINPAIR_EXCL_EN
    // Exclusion request is captured once per scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excl_en_r   <= 1'b0;
            excl_addr_r <= {AW{1'b0}};
        end else if (start_acc_s) begin
            excl_en_r   <= excl_en;
            excl_addr_r <= excl_addr;
        end
    end
`endif

    // Tag the read response: valid one cycle after rd_en, carrying the issuing group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_vld_r <= 1'b0;
            data_grp_r <= {GW{1'b0}};
        end else begin
            data_vld_r <= rd_en;
            if (rd_en) begin
                data_grp_r <= rd_addr;
            end
        end
    end

    // Lane unpacking with addresses; invalid responses and excluded entries read as zero
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            lane_a_s[l] = {data_grp_r, 2'(l)};
            if (!data_vld_r) begin
                lane_v_s[l] = {DW{1'b0}};
            end else begin
                lane_v_s[l] = rd_data[l*DW +: DW];
            end
`ifdef MINPAIR_EXCL_EN
            if (excl_en_r && (lane_a_s[l] == excl_addr_r)) begin
                lane_v_s[l] = {DW{1'b0}};
            end else begin
                lane_v_s[l] = lane_v_s[l];
            end
`endif
        end
    end

    // Insert each lane into the running pair; the response is folded in as it arrives
    // so the final pair is ready on the FLUSH->OUT edge
    always_comb begin
        m1_v_s = run1_v_r;
        m1_a_s = run1_a_r;
        m2_v_s = run2_v_r;
        m2_a_s = run2_a_r;
        for (int l = 0; l < 4; l++) begin
            if (beats(lane_v_s[l], lane_a_s[l], m1_v_s, m1_a_s)) begin
                m2_v_s = m1_v_s;
                m2_a_s = m1_a_s;
                m1_v_s = lane_v_s[l];
                m1_a_s = lane_a_s[l];
            end else if (beats(lane_v_s[l], lane_a_s[l], m2_v_s, m2_a_s)) begin
                m2_v_s = lane_v_s[l];
                m2_a_s = lane_a_s[l];
            end else begin
                m2_v_s = m2_v_s;
            end
        end
    end

    // Running pair: zero value marks an empty slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run1_v_r <= {DW{1'b0}};
            run1_a_r <= {AW{1'b0}};
            run2_v_r <= {DW{1'b0}};
            run2_a_r <= {AW{1'b0}};
        end else if (start_acc_s) begin
            run1_v_r <= {DW{1'b0}};
            run1_a_r <= {AW{1'b0}};
            run2_v_r <= {DW{1'b0}};
            run2_a_r <= {AW{1'b0}};
        end else if (data_vld_r) begin
            run1_v_r <= m1_v_s;
            run1_a_r <= m1_a_s;
            run2_v_r <= m2_v_s;
            run2_a_r <= m2_a_s;
        end
    end

    // Result registers change only when entering OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1      <= {DW{1'b0}};
            min2      <= {DW{1'b0}};
            min1_addr <= {AW{1'b0}};
            min2_addr <= {AW{1'b0}};
            found_cnt <= 2'd0;
        end else if (state_r == FLUSH) begin
            min1      <= m1_v_s;
            min2      <= m2_v_s;
            min1_addr <= m1_a_s;
            min2_addr <= m2_a_s;
            found_cnt <= count_found(m1_v_s, m2_v_s);
        end
    end

endmodule

// File: tb/tb_min_pair_scan_ctrl.sv
// Scoreboard bench for min_pair_scan_ctrl: a buffer model answers reads, a sort-based
// reference predicts each result, and a negedge monitor compares whatever the DUT presents.
module tb_min_pair_scan_ctrl;
    localparam int DW = 11;
    localparam int GW = 5;
    localparam int AW = 7;

    typedef struct {
        logic [DW-1:0] m1;
        logic [DW-1:0] m2;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [1:0]    fc;
        int            cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [GW:0]     num_groups = '0;
    logic            rd_en;
    logic [GW-1:0]   rd_addr;
    logic [4*DW-1:0] rd_data = '0;
    logic            busy;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   min1, min2;
    logic [AW-1:0]   min1_addr, min2_addr;
    logic [1:0]      found_cnt;
    logic            excl_en = 1'b0;
    logic [AW-1:0]   excl_addr = '0;

    logic [DW-1:0]   mem [32][4];
    exp_t            exp_q [$];
    exp_t            last_res;
    exp_t            cur;
    bit              seen = 1'b0;
    int              cyc = 0;
    int              exp_rd_addr = 0;
    int              rd_cnt = 0;
    int              checks = 0;
    int              errors = 0;

    min_pair_scan_ctrl #(.DW(DW), .GW(GW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .min1(min1), .min2(min2), .min1_addr(min1_addr), .min2_addr(min2_addr),
        .found_cnt(found_cnt)
`ifdef MINPAIR_EXCL_EN
        , .excl_en(excl_en), .excl_addr(excl_addr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: gather nonzero (value,address) keys, sort, take the two smallest
    function automatic exp_t model(input int n, input bit xe, input int xa);
        exp_t e;
        int   keys [$];
        for (int a = 0; a < 4 * n; a++) begin
            int v = int'(mem[a / 4][a % 4]);
            if (xe && a == xa) v = 0;
            if (v != 0) keys.push_back((v << 7) | a);
        end
        keys.sort();
        e.m1 = '0; e.a1 = '0; e.m2 = '0; e.a2 = '0; e.cyc = 0;
        e.fc = 2'(keys.size() > 2 ? 2 : keys.size());
        if (keys.size() >= 1) begin
            e.m1 = DW'(keys[0] >> 7);
            e.a1 = AW'(keys[0] & 127);
        end
        if (keys.size() >= 2) begin
            e.m2 = DW'(keys[1] >> 7);
            e.a2 = AW'(keys[1] & 127);
        end
        return e;
    endfunction

    // Buffer model: one-cycle read latency, junk on the bus otherwise
    initial begin
        logic          resp_en;
        logic [GW-1:0] resp_addr;
        forever begin
            @(posedge clk);
            resp_en   = rd_en;
            resp_addr = rd_addr;
            #1;
            if (resp_en) begin
                for (int l = 0; l < 4; l++) rd_data[l*DW +: DW] = mem[resp_addr][l];
            end else begin
                rd_data = {12'($urandom), 32'($urandom)};
            end
        end
    end

    // Monitor: read address order, result scoreboard, result stability
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_rd_addr));
                exp_rd_addr++;
                rd_cnt++;
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("latency", 32'(cyc), 32'(cur.cyc));
                    check("min1", 32'(min1), 32'(cur.m1));
                    check("min1_addr", 32'(min1_addr), 32'(cur.a1));
                    check("min2", 32'(min2), 32'(cur.m2));
                    check("min2_addr", 32'(min2_addr), 32'(cur.a2));
                    check("found_cnt", 32'(found_cnt), 32'(cur.fc));
                    last_res = cur;
                end
            end else if (out_valid) begin
                check("stable_min1", 32'(min1), 32'(last_res.m1));
                check("stable_min2_addr", 32'(min2_addr), 32'(last_res.a2));
                check("stable_found", 32'(found_cnt), 32'(last_res.fc));
            end else begin
                seen = 1'b0;
                check("hold_min1", 32'(min1), 32'(last_res.m1));
                check("hold_found", 32'(found_cnt), 32'(last_res.fc));
            end
        end
    end

    task automatic clear_last();
        last_res.m1 = '0; last_res.m2 = '0; last_res.a1 = '0; last_res.a2 = '0;
        last_res.fc = '0; last_res.cyc = 0;
    endtask

    task automatic fill_mem(input logic [DW-1:0] v);
        for (int g = 0; g < 32; g++)
            for (int l = 0; l < 4; l++) mem[g][l] = v;
    endtask

    task automatic set_word(input int g, input int v0, input int v1, input int v2, input int v3);
        mem[g][0] = DW'(v0); mem[g][1] = DW'(v1); mem[g][2] = DW'(v2); mem[g][3] = DW'(v3);
    endtask

    task automatic run_scan(input int n, input bit xe, input int xa, input int hold);
        int   eff;
        int   t;
        exp_t e;
`ifndef MINPAIR_EXCL_EN
        xe = 1'b0;
`endif
        eff = (n > 32) ? 32 : n;
        e = model(eff, xe, xa);
        @(posedge clk); #1;
        num_groups  = 6'(n);
        excl_en     = xe;
        excl_addr   = 7'(xa);
        start       = 1'b1;
        e.cyc       = cyc + eff + 2;
        exp_q.push_back(e);
        exp_rd_addr = 0;
        rd_cnt      = 0;
        @(posedge clk); #1;
        start      = 1'b0;
        num_groups = 6'($urandom_range(0, 63));
        excl_en    = 1'($urandom);
        excl_addr  = 7'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            t++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("busy_in_out", 32'(busy), 32'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            start = 1'($urandom);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("accepted", 32'(out_valid), 32'd0);
        check("rd_count", 32'(rd_cnt), 32'(eff));
    endtask

    initial begin
        int t;
        clear_last();
        fill_mem('0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_min1", 32'(min1), 32'd0);
        check("rst_found", 32'(found_cnt), 32'd0);
        rst = 1'b0;

        set_word(0, 40, 7, 0, 9);
        set_word(1, 7, 3, 100, 5);
        run_scan(2, 1'b0, 0, 0);

        fill_mem('0);
        set_word(0, 12, 12, 12, 0);
        run_scan(1, 1'b0, 0, 1);

        fill_mem('0);
        mem[2][3] = 11'd1;
        run_scan(3, 1'b0, 0, 0);
        run_scan(0, 1'b0, 0, 0);

        fill_mem(11'd2047);
        run_scan(40, 1'b0, 0, 5);

`ifdef MINPAIR_EXCL_EN
        fill_mem('0);
        set_word(0, 4, 2, 6, 9);
        run_scan(1, 1'b1, 1, 0);
`endif

        // Reset in the middle of a scan, at group 3
        for (int g = 0; g < 32; g++)
            for (int l = 0; l < 4; l++) mem[g][l] = 11'($urandom_range(1, 2047));
        @(posedge clk); #1;
        num_groups  = 6'd8;
        start       = 1'b1;
        exp_rd_addr = 0;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(rd_en && rd_addr == 5'd3) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reach_group3", 32'(rd_addr), 32'd3);
        #2;
        rst = 1'b1;
        clear_last();
        #1;
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_min1", 32'(min1), 32'd0);
        check("mid_rst_min2_addr", 32'(min2_addr), 32'd0);
        check("mid_rst_found", 32'(found_cnt), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", 32'(busy | rd_en | out_valid), 32'd0);

        // Randomized scans, biased toward zeros and duplicate small values
        for (int s = 0; s < 25; s++) begin
            for (int g = 0; g < 32; g++) begin
                for (int l = 0; l < 4; l++) begin
                    case ($urandom_range(0, 2))
                        0:       mem[g][l] = '0;
                        1:       mem[g][l] = 11'($urandom_range(1, 4));
                        default: mem[g][l] = 11'($urandom_range(0, 2047));
                    endcase
                end
            end
            run_scan($urandom_range(0, 40), 1'($urandom), $urandom_range(0, 127),
                     $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
